// File: rtl/alsu_arbiter.sv
// Round-robin front end for the registered ALSU datapath: two valid/ready requesters,
// one issue per cycle, a tag pipeline that routes each result back to its originator,
// and a drain handshake that quiesces the datapath.
module alsu_arbiter #(
    parameter int   LATENCY        = 2,
    parameter logic PRIORITY_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_opcode,
    input  logic [2:0] req0_A,
    input  logic [2:0] req0_B,
    input  logic [6:0] req0_ctrl,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_opcode,
    input  logic [2:0] req1_A,
    input  logic [2:0] req1_B,
    input  logic [6:0] req1_ctrl,
    output logic [2:0] alsu_opcode,
    output logic [2:0] alsu_A,
    output logic [2:0] alsu_B,
    output logic [6:0] alsu_ctrl,
    input  logic [5:0] alsu_out,
    output logic       resp0_valid,
    output logic [5:0] resp0_data,
    output logic       resp1_valid,
    output logic [5:0] resp1_data,
    input  logic       drain_req,
    output logic       drained,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last;
    logic [LATENCY-1:0] r_tag_v;
    logic [LATENCY-1:0] r_tag_id;
    logic               r_resp0_valid;
    logic               r_resp1_valid;
    logic [5:0]         r_resp0_data;
    logic [5:0]         r_resp1_data;

    logic w_grant_en;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;

    // Ready is held low while reset is asserted, even though the state already reads RUN.
    assign w_grant_en = rst_n & (r_state == ST_RUN) & ~drain_req;
    assign w_grant0   = w_grant_en & req0_valid & (~req1_valid | r_last);
    assign w_grant1   = w_grant_en & req1_valid & (~req0_valid | ~r_last);
    assign w_accept   = w_grant0 | w_grant1;

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp0_data  = r_resp0_data;
    assign resp1_data  = r_resp1_data;
    assign busy        = |r_tag_v;
    assign drained     = (r_state == ST_DRAINED);

    // Issue mux: the accepted requester's fields, zero when nothing is accepted.
    always_comb begin
        alsu_opcode = 3'd0;
        alsu_A      = 3'd0;
        alsu_B      = 3'd0;
        alsu_ctrl   = 7'd0;
        if (w_grant0) begin
            alsu_opcode = req0_opcode;
            alsu_A      = req0_A;
            alsu_B      = req0_B;
            alsu_ctrl   = req0_ctrl;
        end else if (w_grant1) begin
            alsu_opcode = req1_opcode;
            alsu_A      = req1_A;
            alsu_B      = req1_B;
            alsu_ctrl   = req1_ctrl;
        end else begin
            alsu_opcode = 3'd0;
        end
    end

    // Drain FSM: DRAIN always runs to completion even if drain_req is withdrawn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (drain_req) r_state <= ST_DRAIN;
                    else           r_state <= ST_RUN;
                end
                ST_DRAIN: begin
                    if (!busy) r_state <= ST_DRAINED;
                    else       r_state <= ST_DRAIN;
                end
                ST_DRAINED: begin
                    if (!drain_req) r_state <= ST_RUN;
                    else            r_state <= ST_DRAINED;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Last-grant pointer; reset value makes PRIORITY_RESET win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= ~PRIORITY_RESET;
        end else if (w_accept) begin
            r_last <= w_grant1;
        end else begin
            r_last <= r_last;
        end
    end

    // Tag pipeline: stage 0 captures {accept, id} every edge, later stages shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0]  <= w_accept;
            r_tag_id[0] <= w_grant1;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Response steering: strobe the owner of the last stage, data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_data  <= 6'd0;
            r_resp1_data  <= 6'd0;
        end else if (r_tag_v[LATENCY-1]) begin
            r_resp0_valid <= ~r_tag_id[LATENCY-1];
            r_resp1_valid <= r_tag_id[LATENCY-1];
            if (r_tag_id[LATENCY-1]) r_resp1_data <= alsu_out;
            else                     r_resp0_data <= alsu_out;
        end else begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alsu_arbiter.sv
// Directed and random bench for alsu_arbiter; a stub datapath supplies alsu_out and a
// queue-based model of outstanding results predicts every handshake and response.
module tb_alsu_arbiter;

    localparam int LAT       = 2;
    localparam int M_RUN     = 0;
    localparam int M_DRAIN   = 1;
    localparam int M_DRAINED = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0] req0_opcode, req0_A, req0_B, req1_opcode, req1_A, req1_B;
    logic [6:0] req0_ctrl, req1_ctrl;
    logic [2:0] alsu_opcode, alsu_A, alsu_B;
    logic [6:0] alsu_ctrl;
    logic [5:0] alsu_out;
    logic       resp0_valid, resp1_valid;
    logic [5:0] resp0_data, resp1_data;
    logic       drain_req, drained, busy;

    always #5 clk = ~clk;

    alsu_arbiter #(.LATENCY(LAT), .PRIORITY_RESET(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_A(req0_A), .req0_B(req0_B), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_A(req1_A), .req1_B(req1_B), .req1_ctrl(req1_ctrl),
        .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_ctrl(alsu_ctrl),
        .alsu_out(alsu_out),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .drain_req(drain_req), .drained(drained), .busy(busy)
    );

    // Simple stand-in ALSU: ctrl = {cin, serial_in, red_A, red_B, bypass_A, bypass_B, dir}.
    function automatic logic [5:0] alsu_fn(input logic [2:0] op, input logic [2:0] a,
                                           input logic [2:0] b, input logic [6:0] ctrl);
        if (ctrl[2]) return {3'd0, a};
        if (ctrl[1]) return {3'd0, b};
        case (op)
            3'd0:    return {3'd0, a & b};
            3'd1:    return {3'd0, a ^ b};
            3'd2:    return 6'(a) + 6'(b) + 6'(ctrl[6]);
            3'd3:    return 6'(a) * 6'(b);
            default: return {a, b};
        endcase
    endfunction

    // Datapath stub: captures the issued op on one edge, result visible after the next.
    logic [5:0] dp_mid, dp_out;
    always @(posedge clk) begin
        dp_mid <= alsu_fn(alsu_opcode, alsu_A, alsu_B, alsu_ctrl);
        dp_out <= dp_mid;
    end
    assign alsu_out = dp_out;

    typedef struct {
        int         due;
        logic       id;
        logic [5:0] data;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         mode;
    logic       last;
    logic       erv0, erv1;
    logic [5:0] erd0, erd1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = M_RUN;
        last = 1'b1;
        erv0 = 1'b0; erv1 = 1'b0;
        erd0 = 6'd0; erd1 = 6'd0;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; drain_req = 1'b0;
        req0_opcode = 3'd0; req0_A = 3'd0; req0_B = 3'd0; req0_ctrl = 7'd0;
        req1_opcode = 3'd0; req1_A = 3'd0; req1_B = 3'd0; req1_ctrl = 7'd0;
    endtask

    task automatic rand_req(input int n, input logic v);
        if (n == 0) begin
            req0_valid = v; req0_opcode = 3'($urandom); req0_A = 3'($urandom);
            req0_B = 3'($urandom); req0_ctrl = 7'($urandom);
        end else begin
            req1_valid = v; req1_opcode = 3'($urandom); req1_A = 3'($urandom);
            req1_B = 3'($urandom); req1_ctrl = 7'($urandom);
        end
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_resp0_valid"}, 16'(resp0_valid), 16'(erv0));
        check({pfx, "_resp1_valid"}, 16'(resp1_valid), 16'(erv1));
        check({pfx, "_resp0_data"},  16'(resp0_data),  16'(erd0));
        check({pfx, "_resp1_data"},  16'(resp1_data),  16'(erd1));
        check({pfx, "_busy"},        16'(busy),        16'(q.size() != 0));
        check({pfx, "_drained"},     16'(drained),     16'(mode == M_DRAINED));
    endtask

    // Asynchronous reset: outputs must drop at once, and ready stays low with valids high.
    task automatic do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        check("rst_ready0", 16'(req0_ready), 16'd0);
        check("rst_ready1", 16'(req1_ready), 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    // One clock: check grant/issue before the edge, advance the model, check responses after.
    task automatic cycle();
        logic        eg0, eg1, ok, in_flight;
        logic [15:0] ealsu;
        exp_t        e;
        eg0 = 1'b0; eg1 = 1'b0;
        ok  = (mode == M_RUN) && !drain_req;
        if (ok && req0_valid && req1_valid) begin
            eg0 = last; eg1 = ~last;
        end else if (ok && req0_valid) begin
            eg0 = 1'b1;
        end else if (ok && req1_valid) begin
            eg1 = 1'b1;
        end
        ealsu = eg0 ? {req0_opcode, req0_A, req0_B, req0_ctrl} :
                eg1 ? {req1_opcode, req1_A, req1_B, req1_ctrl} : 16'd0;
        #1;
        check("ready0", 16'(req0_ready), 16'(eg0));
        check("ready1", 16'(req1_ready), 16'(eg1));
        check("alsu_issue", {alsu_opcode, alsu_A, alsu_B, alsu_ctrl}, ealsu);
        @(posedge clk);
        cyc++;
        in_flight = (q.size() != 0);
        erv0 = 1'b0; erv1 = 1'b0;
        if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.id) begin erv1 = 1'b1; erd1 = e.data; end
            else      begin erv0 = 1'b1; erd0 = e.data; end
        end
        if (eg0) q.push_back('{due: cyc + LAT, id: 1'b0,
                              data: alsu_fn(req0_opcode, req0_A, req0_B, req0_ctrl)});
        if (eg1) q.push_back('{due: cyc + LAT, id: 1'b1,
                              data: alsu_fn(req1_opcode, req1_A, req1_B, req1_ctrl)});
        if (eg0 || eg1) last = eg1;
        if (mode == M_RUN && drain_req)               mode = M_DRAIN;
        else if (mode == M_DRAIN && !in_flight)       mode = M_DRAINED;
        else if (mode == M_DRAINED && !drain_req)     mode = M_RUN;
        @(negedge clk);
        check_outputs("cyc");
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        do_reset();

        // Bypass-A single op: result 5 to requester 0 two edges after accept.
        req0_valid = 1'b1; req0_ctrl = 7'b0000100; req0_A = 3'd5; req0_B = 3'd2;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        check("bypass_resp0_valid", 16'(resp0_valid), 16'd1);
        check("bypass_resp0_data",  16'(resp0_data),  16'd5);
        cycle();

        // Contention right after reset: grants alternate 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rand_req(0, 1'b1);
            rand_req(1, 1'b1);
            cycle();
        end
        idle_inputs();
        repeat (3) cycle();

        // Lone requester 1 streams back-to-back.
        for (int i = 0; i < 4; i++) begin
            rand_req(1, 1'b1);
            cycle();
        end
        idle_inputs();
        repeat (3) cycle();

        // Drain: two ops, then drain_req with a pending request, then release.
        rand_req(0, 1'b1); cycle();
        rand_req(0, 1'b1); cycle();
        rand_req(0, 1'b1);
        drain_req = 1'b1;
        repeat (6) cycle();
        check("drain_drained", 16'(drained), 16'd1);
        drain_req = 1'b0;
        cycle();
        cycle();
        idle_inputs();
        repeat (3) cycle();

        // Reset with an op in flight: no strobe may ever appear.
        rand_req(1, 1'b1); cycle();
        idle_inputs(); cycle();
        do_reset();
        repeat (4) cycle();

        // Reset while a strobe is high: it must drop immediately.
        rand_req(0, 1'b1); cycle();
        idle_inputs(); cycle(); cycle();
        check("pre_rst_strobe", 16'(resp0_valid), 16'd1);
        do_reset();
        repeat (3) cycle();

        // Random traffic with occasional drain episodes.
        for (int i = 0; i < 400; i++) begin
            rand_req(0, 1'($urandom_range(0, 9) < 7));
            rand_req(1, 1'($urandom_range(0, 9) < 7));
            if (!drain_req) drain_req = ($urandom_range(0, 29) == 0);
            else            drain_req = ($urandom_range(0, 5) != 0);
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
